fpga_reset_seq: RTL and testbench

// - Reset sequencer for the FPGA toplevels. It sits between the power-on reset

---
 rtl/fpga_reset_seq_if.sv | 30 +++
 rtl/fpga_reset_seq.sv | 120 ++++++++++++
 tb/tb_fpga_reset_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fpga_reset_seq_if.sv
// Request/status bundle between the reset sequencer and its environment.
// The slave modport is the sequencer side; the master modport drives the requests.
interface fpga_reset_seq_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0] req;
  logic             cause_clr;
  logic             periph_rst_n;
  logic             core_rst_n;
  logic             busy;
  logic [N_REQ-1:0] cause;

  modport master (
    output req,
    output cause_clr,
    input  periph_rst_n,
    input  core_rst_n,
    input  busy,
    input  cause
  );

  modport slave (
    input  req,
    input  cause_clr,
    output periph_rst_n,
    output core_rst_n,
    output busy,
    output cause
  );
endinterface

// File: rtl/fpga_reset_seq.sv
// Reset sequencer: merges level reset requests, releases peripherals first and
// the core after a stagger delay. Define RESET_SEQ_CAUSE_EN to build sticky cause bits.
module fpga_reset_seq #(
  parameter int N_REQ          = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  fpga_reset_seq_if.slave         bus
);

  localparam int MAX_LIM = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = (MAX_LIM > 1) ? $clog2(MAX_LIM) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             periph_q, core_q, busy_q;
  logic             periph_d, core_d, busy_d;
  logic             any_req;

  assign any_req = |bus.req;

  // State register; outputs are registered alongside the state so no input
  // reaches an output combinationally.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= ST_HOLD;
      cnt_q    <= '0;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      core_q   <= core_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and counter logic; any request wins in every state.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable
    // unassigned, which would infer a latch.
    state_d = ST_HOLD;
    cnt_d   = '0;
    case (state_q)
      ST_HOLD: begin
        if (any_req) begin
          state_d = ST_HOLD;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_STAGGER;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_STAGGER: begin
        if (any_req) begin
          state_d = ST_HOLD;
        end else if (cnt_q == STAGGER_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_STAGGER;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        state_d = any_req ? ST_HOLD : ST_RUN;
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase
  end

  // Output decode from the next state, registered above.
  always_comb begin
    periph_d = (state_d != ST_HOLD);
    core_d   = (state_d == ST_RUN);
    busy_d   = ~core_d;
  end

  assign bus.periph_rst_n = periph_q;
  assign bus.core_rst_n   = core_q;
  assign bus.busy         = busy_q;

`ifdef RESET_SEQ_CAUSE_EN
  logic [N_REQ-1:0] cause_q;

  // Set dominates clear; only rst wipes the record.
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= '0;
    end else begin
      cause_q <= (cause_q & ~{N_REQ{bus.cause_clr}}) | bus.req;
    end
  end

  assign bus.cause = cause_q;
`else
  logic unused_cause_clr;

  assign unused_cause_clr = bus.cause_clr;
  assign bus.cause        = '0;
`endif

endmodule

// File: tb/tb_fpga_reset_seq.sv
// Directed self-checking bench for fpga_reset_seq with default parameters.
// Honours RESET_SEQ_CAUSE_EN for the expected cause values.
module tb_fpga_reset_seq;

  localparam int N_REQ = 2;

  // {periph_rst_n, core_rst_n, busy}
  localparam logic [2:0] OUT_HOLD = 3'b001;
  localparam logic [2:0] OUT_RUN  = 3'b110;

  typedef struct {
    logic [1:0] req;
    logic       clr;
    logic [2:0] outs;
    logic [1:0] cause;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  fpga_reset_seq_if #(.N_REQ(N_REQ)) bus ();

  fpga_reset_seq #(
    .N_REQ          (N_REQ),
    .HOLD_CYCLES    (16),
    .STAGGER_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] exp_cause(input logic [1:0] c);
`ifdef RESET_SEQ_CAUSE_EN
    return c;
`else
    return 2'b00;
`endif
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] req, input logic clr);
    bus.req       = req;
    bus.cause_clr = clr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {5'b0, bus.periph_rst_n, bus.core_rst_n, bus.busy};
  endfunction

  // Edge 1 is the first edge after the restarting event with no request.
  task automatic release_seq(input string name, input int last_edge);
    logic [2:0] exp;
    for (int e = 1; e <= last_edge; e++) begin
      step(2'b00, 1'b0);
      exp = {(e >= 16), (e >= 20), (e < 20)};
      check($sformatf("%s_e%0d", name, e), outs(), {5'b0, exp});
    end
  endtask

  vec_t vecs[8];

  initial begin
    n_checks = 0;
    n_pass   = 0;

    vecs[0] = '{req: 2'b00, clr: 1'b1, outs: OUT_RUN,  cause: 2'b00};
    vecs[1] = '{req: 2'b10, clr: 1'b0, outs: OUT_HOLD, cause: 2'b10};
    vecs[2] = '{req: 2'b00, clr: 1'b0, outs: OUT_HOLD, cause: 2'b10};
    vecs[3] = '{req: 2'b01, clr: 1'b1, outs: OUT_HOLD, cause: 2'b01};
    vecs[4] = '{req: 2'b00, clr: 1'b1, outs: OUT_HOLD, cause: 2'b00};
    vecs[5] = '{req: 2'b11, clr: 1'b0, outs: OUT_HOLD, cause: 2'b11};
    vecs[6] = '{req: 2'b11, clr: 1'b1, outs: OUT_HOLD, cause: 2'b11};
    vecs[7] = '{req: 2'b00, clr: 1'b1, outs: OUT_HOLD, cause: 2'b00};

    // Reset state
    rst = 1'b1;
    repeat (3) step(2'b00, 1'b0);
    check("reset_outs", outs(), {5'b0, OUT_HOLD});
    check("reset_cause", {6'b0, bus.cause}, 8'h00);

    // Power-on release timing
    rst = 1'b0;
    release_seq("por", 20);

    // One-cycle req[1] pulse in RUN
    step(2'b10, 1'b0);
    check("run_pulse_outs", outs(), {5'b0, OUT_HOLD});
    check("run_pulse_cause", {6'b0, bus.cause}, {6'b0, exp_cause(2'b10)});
    release_seq("run_pulse", 20);

    // req[0] held for 100 cycles
    for (int i = 0; i < 100; i++) begin
      step(2'b01, 1'b0);
      if (i % 25 == 0 || i == 99)
        check($sformatf("held_%0d", i), outs(), {5'b0, OUT_HOLD});
    end
    check("held_cause", {6'b0, bus.cause}, {6'b0, exp_cause(2'b11)});
    release_seq("held", 20);

    // Pulse in STAGGER, two edges after periph release
    step(2'b01, 1'b0);
    check("stag_restart", outs(), {5'b0, OUT_HOLD});
    release_seq("stag_pre", 18);
    step(2'b01, 1'b0);
    check("stag_pulse", outs(), {5'b0, OUT_HOLD});
    release_seq("stag_post", 20);

    // Cause set/clear vectors, starting from RUN
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].req, vecs[i].clr);
      check($sformatf("vec%0d_outs", i), outs(), {5'b0, vecs[i].outs});
      check($sformatf("vec%0d_cause", i), {6'b0, bus.cause}, {6'b0, exp_cause(vecs[i].cause)});
    end

    // rst in mid-STAGGER
    step(2'b01, 1'b0);
    check("pre_rst_cause", {6'b0, bus.cause}, {6'b0, exp_cause(2'b01)});
    release_seq("pre_rst", 17);
    rst = 1'b1;
    step(2'b00, 1'b0);
    check("mid_rst_outs", outs(), {5'b0, OUT_HOLD});
    check("mid_rst_cause", {6'b0, bus.cause}, 8'h00);
    rst = 1'b0;
    release_seq("post_rst", 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
